// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle: ALU stream, long-latency handshake stream,
// register-file write port and hazard query.
interface wb_arbiter_if;
  logic        alu_valid_i;
  logic [5:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        alu_stall_o;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [5:0]  lsu_rd_i;
  logic [31:0] lsu_data_i;
  logic [31:0] wb_data_o;
  logic [5:0]  wb_sel_o;
  logic        wb_en_o;
  logic [5:0]  q_sel_i;
  logic        q_busy_o;

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i, lsu_valid_i, lsu_rd_i, lsu_data_i, q_sel_i,
    output alu_stall_o, lsu_ready_o, wb_data_o, wb_sel_o, wb_en_o, q_busy_o
  );

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i, lsu_valid_i, lsu_rd_i, lsu_data_i, q_sel_i,
    input  alu_stall_o, lsu_ready_o, wb_data_o, wb_sel_o, wb_en_o, q_busy_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// Merges the ALU result stream and the buffered long-latency stream onto the
// single register-file write port, with bounded starvation of the FIFO head.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst_n_i,
  input  logic         ce_i,
  wb_arbiter_if.slave  bus
);
  localparam int unsigned RW = 6;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_FIFO, SRC_LSU} src_e;

  logic [RW-1:0] fifo_rd   [2];
  logic [DW-1:0] fifo_data [2];
  logic          head;
  logic [1:0]    count;
  logic [CW-1:0] starve;
  logic [DW-1:0] wb_data;
  logic [RW-1:0] wb_sel;
  logic          wb_en;

  logic          fifo_empty, fifo_full, stall, ready, accept, push, pop, wr_idx;
  src_e          src;
  logic [RW-1:0] win_rd;
  logic [DW-1:0] win_data;

  assign fifo_empty = (count == 2'd0);
  assign fifo_full  = (count == 2'd2);
  assign stall      = (starve >= CW'(STARVE_LIMIT)) && !fifo_empty;
  assign ready      = ce_i && !fifo_full;
  assign accept     = bus.lsu_valid_i && ready;
  assign wr_idx     = head ^ count[0];

  // Winner selection; a stall overrides any ALU request.
  always_comb begin
    src      = SRC_NONE;
    win_rd   = '0;
    win_data = '0;
    if (stall || (!bus.alu_valid_i && !fifo_empty)) begin
      src      = SRC_FIFO;
      win_rd   = fifo_rd[head];
      win_data = fifo_data[head];
    end else if (bus.alu_valid_i) begin
      src      = SRC_ALU;
      win_rd   = bus.alu_rd_i;
      win_data = bus.alu_data_i;
    end else if (bus.lsu_valid_i) begin
      src      = SRC_LSU;
      win_rd   = bus.lsu_rd_i;
      win_data = bus.lsu_data_i;
    end
  end

  assign pop  = ce_i && (src == SRC_FIFO);
  assign push = accept && (src != SRC_LSU);

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fifo_rd[0]   <= '0;
      fifo_rd[1]   <= '0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      head         <= 1'b0;
      count        <= 2'd0;
      starve       <= '0;
      wb_data      <= '0;
      wb_sel       <= '0;
      wb_en        <= 1'b0;
    end else if (ce_i) begin
      if (push) begin
        fifo_rd[wr_idx]   <= bus.lsu_rd_i;
        fifo_data[wr_idx] <= bus.lsu_data_i;
      end
      if (pop) head <= ~head;
      count <= count + 2'(push) - 2'(pop);
      if (pop || fifo_empty)
        starve <= '0;
      else if ((src == SRC_ALU) && (starve != '1))
        starve <= starve + CW'(1);
      // x0 winners are consumed but never written
      wb_en <= (src != SRC_NONE) && (win_rd != '0);
      if (src != SRC_NONE) begin
        wb_sel  <= win_rd;
        wb_data <= win_data;
      end
    end
  end

  assign bus.alu_stall_o = stall;
  assign bus.lsu_ready_o = ready;
  assign bus.wb_data_o   = wb_data;
  assign bus.wb_sel_o    = wb_sel;
  assign bus.wb_en_o     = wb_en;
  assign bus.q_busy_o    = (bus.q_sel_i != '0) &&
                           (((count != 2'd0) && (fifo_rd[head]  == bus.q_sel_i)) ||
                            ((count == 2'd2) && (fifo_rd[~head] == bus.q_sel_i)) ||
                            (wb_en && (wb_sel == bus.q_sel_i)));
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter against a queue-based
// model of the arbitration rules.
module tb_wb_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic ce;
  wb_arbiter_if bus ();

  wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk     (clk),
    .rst_n_i (rst_n),
    .ce_i    (ce),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // model state
  logic [37:0] mq[$];
  int          mcnt;
  logic        m_en;
  logic [5:0]  m_sel;
  logic [31:0] m_data;

  // pre-edge expectations and observations of the last advance()
  logic exp_ready, exp_stall, exp_busy, obs_ready, obs_stall, obs_busy;

  task automatic model_reset();
    mq.delete();
    mcnt = 0; m_en = 1'b0; m_sel = '0; m_data = '0;
  endtask

  function automatic logic model_busy();
    if (bus.q_sel_i == 6'd0) return 1'b0;
    foreach (mq[i]) if (mq[i][37:32] == bus.q_sel_i) return 1'b1;
    return m_en && (m_sel == bus.q_sel_i);
  endfunction

  task automatic model_step();
    int sz, src;
    logic stall, acc;
    logic [37:0] win;
    sz = mq.size();
    stall = (mcnt >= LIMIT) && (sz > 0);
    if (!ce) return;
    if (stall) src = 2;
    else if (bus.alu_valid_i) src = 1;
    else if (sz > 0) src = 2;
    else if (bus.lsu_valid_i) src = 3;
    else src = 0;
    acc = bus.lsu_valid_i && (sz < 2);
    win = '0;
    if (src == 1) win = {bus.alu_rd_i, bus.alu_data_i};
    if (src == 2) win = mq[0];
    if (src == 3) win = {bus.lsu_rd_i, bus.lsu_data_i};
    if (src == 2 || sz == 0) mcnt = 0;
    else if (src == 1 && mcnt < 15) mcnt++;
    if (src == 2) void'(mq.pop_front());
    if (acc && src != 3) mq.push_back({bus.lsu_rd_i, bus.lsu_data_i});
    m_en = (src != 0) && (win[37:32] != 6'd0);
    if (m_en) {m_sel, m_data} = win;
  endtask

  // One clock: sample combinational outputs at negedge, step model, settle after posedge.
  task automatic advance();
    @(negedge clk);
    exp_ready = ce && (mq.size() < 2);
    exp_stall = (mcnt >= LIMIT) && (mq.size() > 0);
    exp_busy  = model_busy();
    obs_ready = bus.lsu_ready_o;
    obs_stall = bus.alu_stall_o;
    obs_busy  = bus.q_busy_o;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid_i = 1'b0; bus.alu_rd_i = '0; bus.alu_data_i = '0;
    bus.lsu_valid_i = 1'b0; bus.lsu_rd_i = '0; bus.lsu_data_i = '0;
    bus.q_sel_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    ce = 1'b1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({bus.wb_en_o, bus.wb_sel_o, bus.wb_data_o} !== 39'd0) begin
      tests_failed++;
      $display("FAIL reset_wb got en=%b sel=%0d data=%h want 0", bus.wb_en_o, bus.wb_sel_o, bus.wb_data_o);
    end
    tests_run++;
    if ({bus.alu_stall_o, bus.lsu_ready_o, bus.q_busy_o} !== 3'b010) begin
      tests_failed++;
      $display("FAIL reset_flags got stall/ready/busy=%b want 010", {bus.alu_stall_o, bus.lsu_ready_o, bus.q_busy_o});
    end
  endtask

  task automatic test_alu();
    do_reset();
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = 6'd5; bus.alu_data_i = 32'hDEADBEEF;
    advance();
    tests_run++;
    if ({bus.wb_en_o, bus.wb_sel_o, bus.wb_data_o} !== {1'b1, 6'd5, 32'hDEADBEEF}) begin
      tests_failed++;
      $display("FAIL alu_rd5 got en=%b sel=%0d data=%h want 1/5/deadbeef", bus.wb_en_o, bus.wb_sel_o, bus.wb_data_o);
    end
    bus.alu_rd_i = 6'd0;
    advance();
    tests_run++;
    if (bus.wb_en_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL alu_x0 got en=%b want 0", bus.wb_en_o);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 6'd33; bus.lsu_data_i = 32'h12345678;
    advance();
    idle_inputs();
    tests_run++;
    if ({bus.wb_en_o, bus.wb_sel_o, bus.wb_data_o} !== {1'b1, 6'd33, 32'h12345678}) begin
      tests_failed++;
      $display("FAIL bypass got en=%b sel=%0d data=%h want 1/33/12345678", bus.wb_en_o, bus.wb_sel_o, bus.wb_data_o);
    end
    advance();
    tests_run++;
    if ({obs_ready, obs_stall, bus.wb_en_o} !== 3'b100) begin
      tests_failed++;
      $display("FAIL bypass_empty got ready/stall/en=%b want 100", {obs_ready, obs_stall, bus.wb_en_o});
    end
  endtask

  task automatic test_backpressure();
    int alu_n, lsu_n, first_stall;
    do_reset();
    alu_n = 1; lsu_n = 0; first_stall = -1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      bus.alu_valid_i = 1'b1; bus.alu_rd_i = 6'(alu_n); bus.alu_data_i = 32'h1000 + 32'(alu_n);
      bus.lsu_valid_i = (lsu_n < 3); bus.lsu_rd_i = 6'(20 + lsu_n); bus.lsu_data_i = 32'hA000 + 32'(lsu_n);
      bus.q_sel_i = 6'(20 + (cyc % 3));
      advance();
      if (obs_stall && first_stall < 0) first_stall = cyc;
      if (!exp_stall) alu_n++;
      if (exp_ready && bus.lsu_valid_i) lsu_n++;
      tests_run++;
      if ({obs_ready, obs_stall, obs_busy} !== {exp_ready, exp_stall, exp_busy}) begin
        tests_failed++;
        $display("FAIL bp_flags cyc=%0d got ready/stall/busy=%b want %b", cyc,
                 {obs_ready, obs_stall, obs_busy}, {exp_ready, exp_stall, exp_busy});
      end
      tests_run++;
      if ({bus.wb_en_o, bus.wb_en_o ? {bus.wb_sel_o, bus.wb_data_o} : 38'd0} !== {m_en, m_en ? {m_sel, m_data} : 38'd0}) begin
        tests_failed++;
        $display("FAIL bp_wb cyc=%0d got en=%b sel=%0d data=%h want en=%b sel=%0d data=%h", cyc,
                 bus.wb_en_o, bus.wb_sel_o, bus.wb_data_o, m_en, m_sel, m_data);
      end
    end
    tests_run++;
    if (first_stall !== 5) begin
      tests_failed++;
      $display("FAIL bp_first_stall got cycle %0d want 5", first_stall);
    end
    idle_inputs();
  endtask

  task automatic test_push_pop();
    do_reset();
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = 6'd3; bus.alu_data_i = 32'h33;
    bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 6'd10; bus.lsu_data_i = 32'hB0;
    advance();
    bus.alu_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.lsu_rd_i = 6'(11 + i); bus.lsu_data_i = 32'hB1 + 32'(i);
      bus.q_sel_i = 6'(11 + i);
      advance();
      tests_run++;
      if ({obs_ready, bus.wb_en_o, bus.wb_sel_o, bus.wb_data_o} !== {1'b1, 1'b1, 6'(10 + i), 32'hB0 + 32'(i)}) begin
        tests_failed++;
        $display("FAIL pushpop i=%0d got ready=%b en=%b sel=%0d data=%h want 1/1/%0d/%h", i,
                 obs_ready, bus.wb_en_o, bus.wb_sel_o, bus.wb_data_o, 10 + i, 32'hB0 + 32'(i));
      end
    end
    bus.lsu_valid_i = 1'b0;
    advance();
    tests_run++;
    if ({bus.wb_en_o, bus.wb_sel_o, bus.wb_data_o} !== {1'b1, 6'd18, 32'hB8}) begin
      tests_failed++;
      $display("FAIL pushpop_last got en=%b sel=%0d data=%h want 1/18/b8", bus.wb_en_o, bus.wb_sel_o, bus.wb_data_o);
    end
    idle_inputs();
  endtask

  // Random traffic with ce_i gating, including a forced 3-cycle ce_i=0 window.
  task automatic test_random(input int cycles, input string tag);
    logic consumed_alu, consumed_lsu;
    do_reset();
    for (int cyc = 0; cyc < cycles; cyc++) begin
      ce = !(cyc >= 20 && cyc < 23) && ($urandom_range(0, 7) != 0);
      bus.q_sel_i = 6'($urandom_range(0, 35));
      advance();
      tests_run++;
      if ({obs_ready, obs_stall, obs_busy} !== {exp_ready, exp_stall, exp_busy}) begin
        tests_failed++;
        $display("FAIL %s_flags cyc=%0d got ready/stall/busy=%b want %b", tag, cyc,
                 {obs_ready, obs_stall, obs_busy}, {exp_ready, exp_stall, exp_busy});
      end
      tests_run++;
      if ({bus.wb_en_o, bus.wb_en_o ? {bus.wb_sel_o, bus.wb_data_o} : 38'd0} !== {m_en, m_en ? {m_sel, m_data} : 38'd0}) begin
        tests_failed++;
        $display("FAIL %s_wb cyc=%0d got en=%b sel=%0d data=%h want en=%b sel=%0d data=%h", tag, cyc,
                 bus.wb_en_o, bus.wb_sel_o, bus.wb_data_o, m_en, m_sel, m_data);
      end
      consumed_alu = ce && !exp_stall;
      consumed_lsu = exp_ready;
      if (!bus.alu_valid_i || consumed_alu) begin
        bus.alu_valid_i = ($urandom_range(0, 2) != 0);
        bus.alu_rd_i = 6'($urandom_range(0, 35)); bus.alu_data_i = $urandom;
      end
      if (!bus.lsu_valid_i || consumed_lsu) begin
        bus.lsu_valid_i = ($urandom_range(0, 1) != 0);
        bus.lsu_rd_i = 6'($urandom_range(0, 35)); bus.lsu_data_i = $urandom;
      end
    end
    ce = 1'b1;
    idle_inputs();
  endtask

  task automatic test_reset_query();
    do_reset();
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = 6'd1; bus.alu_data_i = 32'h1;
    bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 6'd7; bus.lsu_data_i = 32'h77;
    advance();
    bus.alu_rd_i = 6'd2; bus.alu_data_i = 32'h2;
    bus.lsu_rd_i = 6'd9; bus.lsu_data_i = 32'h99;
    advance();
    bus.lsu_valid_i = 1'b0;
    bus.q_sel_i = 6'd9;
    #1;
    tests_run++;
    if ({bus.q_busy_o, bus.lsu_ready_o} !== 2'b10) begin
      tests_failed++;
      $display("FAIL query9 got busy/ready=%b want 10", {bus.q_busy_o, bus.lsu_ready_o});
    end
    bus.q_sel_i = 6'd0;
    #1;
    tests_run++;
    if (bus.q_busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL query0 got busy=%b want 0", bus.q_busy_o);
    end
    bus.q_sel_i = 6'd9;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if ({bus.wb_en_o, bus.wb_sel_o, bus.wb_data_o, bus.alu_stall_o, bus.lsu_ready_o, bus.q_busy_o} !== {39'd0, 3'b010}) begin
      tests_failed++;
      $display("FAIL async_reset got en=%b sel=%0d data=%h stall=%b ready=%b busy=%b want zeros ready=1",
               bus.wb_en_o, bus.wb_sel_o, bus.wb_data_o, bus.alu_stall_o, bus.lsu_ready_o, bus.q_busy_o);
    end
    bus.alu_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      advance();
      tests_run++;
      if (bus.wb_en_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL post_reset_drain i=%0d got en=%b sel=%0d want en=0", i, bus.wb_en_o, bus.wb_sel_o);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ce = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_alu();
    test_bypass();
    test_backpressure();
    test_push_pop();
    test_random(300, "rand_a");
    test_random(300, "rand_b");
    test_reset_query();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter for the RISC-V core. It merges two result streams into the register file's single write port (`in_i`/`in_sel_i`/`in_en_i`):
- the single-cycle ALU stream, which has no backpressure;
- the long-latency stream (loads, mul/div), which has a valid/ready handshake.

Long-latency results are buffered in a 2-entry FIFO, and a bounded-starvation counter stalls the ALU when the FIFO has waited too long. It sits directly upstream of the register file and shares its clock and clock enable.

## Interface
- `STARVE_LIMIT`, default 4: number of consecutive cycles the FIFO head may lose to the ALU before `alu_stall_o` forces a drain (range 1..15).
- `clk` in 1: core clock.
- `rst_n_i` in 1: one clock; reset is asynchronous and active-low.
- `ce_i` in 1: clock enable, the same signal the register file receives; when 0 all state holds.
- `alu_valid_i` in 1: ALU result present this cycle.
- `alu_rd_i` in 6: destination register, 0..35 (32..35 = q0..q3).
- `alu_data_i` in 32: ALU result.
- `alu_stall_o` out 1: upstream must hold the ALU result and the pipeline.
- `lsu_valid_i` in 1: long-latency result offered.
- `lsu_ready_o` out 1: result accepted when valid & ready at a `ce_i` edge.
- `lsu_rd_i` in 6: destination register.
- `lsu_data_i` in 32: result.
- `wb_data_o` out 32: to register file `in_i`.
- `wb_sel_o` out 6: to register file `in_sel_i`.
- `wb_en_o` out 1: to register file `in_en_i`.
- `q_sel_i` in 6: hazard query register number.
- `q_busy_o` out 1: combinational; 1 if `q_sel_i` (nonzero) matches any valid FIFO entry or the `wb_*` stage with `wb_en_o`=1.

## Operation
- Output stage: `wb_data_o`, `wb_sel_o` and `wb_en_o` are registered and are loaded once per `ce_i`=1 edge.
- Selection order each ce cycle:
  - **Winner, in priority order:**
    1. If `alu_stall_o`=1, the FIFO head wins.
    2. Else if `alu_valid_i`, the ALU wins.
    3. Else if the FIFO is non-empty, the FIFO head wins.
    4. Else if `lsu_valid_i` and the FIFO is empty, the LSU input bypasses the FIFO and is written directly.
    5. Otherwise `wb_en_o`<=0.
  - **LSU input, if accepted and not bypassed:** pushed into the FIFO.
- x0 rule: any winner with rd=0 is consumed (FIFO pops, handshake completes) but `wb_en_o`<=0.
- `lsu_ready_o` = `ce_i` & (count<2).
  - Push and pop may happen on the same edge; the count then stays unchanged.
  - No push-through when full: a full FIFO deasserts ready even if it pops that cycle.
- Starvation counter (4 bits):
  - Increments on each ce edge where the FIFO is non-empty and the ALU wins.
  - Clears on any FIFO pop, or when the FIFO is empty.
  - `alu_stall_o` = (counter >= `STARVE_LIMIT`) & FIFO non-empty. It is a combinational decode of registered state.
- While `alu_stall_o`=1, `alu_valid_i` is ignored. Upstream holds `alu_*` stable until `alu_stall_o` falls.
- Ordering:
  - FIFO entries drain in arrival order.
  - Ordering between an ALU and an LSU result to the same rd is guaranteed upstream via `q_busy_o`; the arbiter does not check it.
- `ce_i`=0:
  - No state changes; `wb_*` hold.
  - `lsu_ready_o`=0; `alu_valid_i` is ignored.

## Timing
- Reset (asynchronous, `rst_n_i`=0): `wb_data_o`=0, `wb_sel_o`=0, `wb_en_o`=0, FIFO empty, counter=0. This gives `alu_stall_o`=0, `lsu_ready_o`=`ce_i`, `q_busy_o`=0.
- Reset mid-operation discards buffered entries without writing them.
- Latency, ALU: result visible on `wb_*` 1 ce cycle after the `alu_valid_i` edge.
- Latency, LSU: 1 cycle via bypass; otherwise 1 cycle after it reaches the FIFO head and wins.
- The register file commits `wb_*` on the following edge, so end-to-end commit happens 2 ce edges after the input.
- Worst-case FIFO head wait: `STARVE_LIMIT`+1 ce cycles.
- A FIFO entry, or `wb_*` with `wb_en_o`=1, is visible on `q_busy_o` from the cycle after it is accepted until the cycle after `wb_en_o` drops for it.

## Test plan
- **ALU stream:** reset, then `alu_valid_i`=1, rd=5, data=0xDEADBEEF. Next cycle: `wb_en_o`=1, `wb_sel_o`=5, `wb_data_o`=0xDEADBEEF. With rd=0 instead, `wb_en_o`=0.
- **LSU bypass:** with the ALU idle and FIFO empty, LSU rd=33, data=0x12345678. One cycle later: `wb_sel_o`=33, `wb_data_o`=0x12345678; FIFO stays empty.
- **Backpressure:**
  - ALU valid every cycle with rd=1..; LSU offers 3 results.
  - First two accepted; `lsu_ready_o`=0 while count=2.
  - After 4 ALU wins, `alu_stall_o`=1 and the LSU head is written next cycle; the ALU result held during the stall is written afterwards, unchanged.
- **Simultaneous push/pop:**
  - FIFO count=1, ALU idle, new LSU valid.
  - Head written, new entry stored, count stays 1.
  - FIFO order is preserved across 8 back-to-back results.
- **ce_i gating:** hold `ce_i`=0 for 3 cycles mid-stream. `wb_*`, FIFO, counter and `alu_stall_o` are unchanged, and `lsu_ready_o`=0. The stream resumes identically.
- **Reset / query:**
  - With 2 entries buffered (rd=7, rd=9), `q_sel_i`=9 gives `q_busy_o`=1; `q_sel_i`=0 gives 0.
  - Assert `rst_n_i`=0 asynchronously mid-cycle: all outputs go to their reset values immediately, and neither entry is ever written.
